// File: rtl/hazard_ctrl_if.sv
// Hazard-control bus: decode-stage instruction, EX redirect and counter clear
// in; stall/flush/bubble controls, forwarding selects and counters out.
interface hazard_ctrl_if #(
    parameter int FWD_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 32
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic              de_valid;
    logic [REG_AW-1:0] de_rs1;
    logic [REG_AW-1:0] de_rs2;
    logic              de_use_rs1;
    logic              de_use_rs2;
    logic [REG_AW-1:0] de_rd;
    logic              de_rd_we;
    logic              de_is_load;
    logic              ex_branch_taken;
    logic              cnt_clr;

    logic              stall;
    logic              flush_de;
    logic              bubble_ex;
    logic [SEL_W-1:0]  fwd_sel_rs1;
    logic [SEL_W-1:0]  fwd_sel_rs2;
    logic              retire;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  retire_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2,
               de_rd, de_rd_we, de_is_load, ex_branch_taken, cnt_clr,
        input  stall, flush_de, bubble_ex, fwd_sel_rs1, fwd_sel_rs2,
               retire, cycle_cnt, retire_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2,
               de_rd, de_rd_we, de_is_load, ex_branch_taken, cnt_clr,
        output stall, flush_de, bubble_ex, fwd_sel_rs1, fwd_sel_rs2,
               retire, cycle_cnt, retire_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow copy of EX..writeback, operand forwarding
// selects, load-use stall, branch flush and saturating performance counters.
module hazard_ctrl #(
    parameter int FWD_STAGES = 2,
    parameter int LOAD_READY = 3,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);
    localparam int NSLOT = FWD_STAGES + 1;

    if (FWD_STAGES < 1 || FWD_STAGES > 4 || LOAD_READY < 2 || LOAD_READY > NSLOT) begin : g_bad_param
        $error("hazard_ctrl: illegal FWD_STAGES/LOAD_READY combination");
    end

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
        logic              is_load;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
    } slot_t;

    // r_slot[1] is EX, r_slot[NSLOT] is writeback.
    slot_t            r_slot [1:NSLOT];
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_retire_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    slot_t            w_de_slot;
    logic [SEL_W-1:0] w_fwd1;
    logic [SEL_W-1:0] w_fwd2;
    logic             w_lu1;
    logic             w_lu2;
    logic             w_load_use;
    logic             w_eff_branch;
    logic             w_stall;
    logic             w_flush;
    logic             w_retire;
    logic             w_accept;

    function automatic logic slot_writes(input slot_t s, input logic [REG_AW-1:0] r);
        return s.valid && s.rd_we && (s.rd == r) && (r != '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        w_de_slot         = '0;
        w_de_slot.valid   = bus.de_valid;
        w_de_slot.rd      = bus.de_rd;
        w_de_slot.rd_we   = bus.de_rd_we;
        w_de_slot.is_load = bus.de_is_load;
        w_de_slot.rs1     = bus.de_rs1;
        w_de_slot.rs2     = bus.de_rs2;
        w_de_slot.use_rs1 = bus.de_use_rs1;
        w_de_slot.use_rs2 = bus.de_use_rs2;
    end

    // Forwarding for the EX instruction: scan oldest to youngest so the
    // youngest writer is the last one assigned.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_fwd1 = '0;
        w_fwd2 = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (r_slot[1].use_rs1 && slot_writes(r_slot[k+1], r_slot[1].rs1)) w_fwd1 = SEL_W'(k);
            if (r_slot[1].use_rs2 && slot_writes(r_slot[k+1], r_slot[1].rs2)) w_fwd2 = SEL_W'(k);
        end
    end

    // A decode source stalls only if its youngest in-flight writer is a load
    // that will still be short of LOAD_READY when decode moves into EX.
    always_comb begin
        w_lu1 = 1'b0;
        w_lu2 = 1'b0;
        for (int j = FWD_STAGES; j >= 1; j--) begin
            if (slot_writes(r_slot[j], bus.de_rs1)) w_lu1 = r_slot[j].is_load && (j + 1 < LOAD_READY);
            if (slot_writes(r_slot[j], bus.de_rs2)) w_lu2 = r_slot[j].is_load && (j + 1 < LOAD_READY);
        end
        w_load_use = bus.de_valid && ((bus.de_use_rs1 && w_lu1) || (bus.de_use_rs2 && w_lu2));
    end

    assign w_eff_branch = bus.ex_branch_taken && r_slot[1].valid;
    assign w_flush      = reset && w_eff_branch;
    assign w_stall      = reset && w_load_use && !w_eff_branch;
    assign w_retire     = reset && r_slot[NSLOT].valid;
    assign w_accept     = bus.de_valid && !w_stall && !w_flush;

    assign bus.stall       = w_stall;
    assign bus.flush_de    = w_flush;
    assign bus.bubble_ex   = w_stall || w_flush;
    assign bus.retire      = w_retire;
    assign bus.fwd_sel_rs1 = reset ? w_fwd1 : '0;
    assign bus.fwd_sel_rs2 = reset ? w_fwd2 : '0;

    // NOTE: the slot array is a handful of flops, not a RAM, so resetting every
    // entry is cheap and guarantees no stale writer survives reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i <= NSLOT; i++) r_slot[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every slot sample its predecessor's old value.
            r_slot[1] <= w_accept ? w_de_slot : '0;
            for (int i = 2; i <= NSLOT; i++) r_slot[i] <= r_slot[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || bus.cnt_clr) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_cycle_cnt  <= sat_inc(r_cycle_cnt, 1'b1);
            r_retire_cnt <= sat_inc(r_retire_cnt, w_retire);
            r_stall_cnt  <= sat_inc(r_stall_cnt, w_stall);
            r_flush_cnt  <= sat_inc(r_flush_cnt, w_flush);
        end
    end

    assign bus.cycle_cnt  = r_cycle_cnt;
    assign bus.retire_cnt = r_retire_cnt;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: default instance (A) and a
// FWD_STAGES=3 / LOAD_READY=4 / CNT_W=4 instance (B).
module tb_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    hazard_ctrl_if #(.FWD_STAGES(2), .REG_AW(5), .CNT_W(32)) if_a ();
    hazard_ctrl_if #(.FWD_STAGES(3), .REG_AW(5), .CNT_W(4))  if_b ();

    hazard_ctrl #(.FWD_STAGES(2), .LOAD_READY(3), .REG_AW(5), .CNT_W(32)) dut_a (
        .clk(clk), .reset(rst_a), .bus(if_a));
    hazard_ctrl #(.FWD_STAGES(3), .LOAD_READY(4), .REG_AW(5), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rst_b), .bus(if_b));

    typedef enum {SIG_STALL, SIG_FLUSH, SIG_BUBBLE, SIG_FS1, SIG_FS2, SIG_RETIRE,
                  SIG_CYC, SIG_RCNT, SIG_SCNT, SIG_FCNT} sig_e;

    typedef struct {
        int          cyc;
        int          dut;
        sig_e        sig;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
    } ins_t;

    sb_t sb_q[$];
    sb_t sb_keep[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ins_t nop();
        return '0;
    endfunction

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2);
        ins_t i;
        i = '0; i.v = 1'b1; i.rd = rd; i.we = 1'b1;
        i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
        return i;
    endfunction

    function automatic ins_t load(input logic [4:0] rd);
        ins_t i;
        i = alu(rd, 5'd0, 5'd0, 1'b1, 1'b0);
        i.ld = 1'b1;
        return i;
    endfunction

    task automatic drive(input int dut, input ins_t i, input logic br, input logic clr);
        if (dut == 0) begin
            if_a.de_valid = i.v;  if_a.de_rd = i.rd; if_a.de_rd_we = i.we; if_a.de_is_load = i.ld;
            if_a.de_rs1 = i.rs1;  if_a.de_use_rs1 = i.u1;
            if_a.de_rs2 = i.rs2;  if_a.de_use_rs2 = i.u2;
            if_a.ex_branch_taken = br; if_a.cnt_clr = clr;
        end else begin
            if_b.de_valid = i.v;  if_b.de_rd = i.rd; if_b.de_rd_we = i.we; if_b.de_is_load = i.ld;
            if_b.de_rs1 = i.rs1;  if_b.de_use_rs1 = i.u1;
            if_b.de_rs2 = i.rs2;  if_b.de_use_rs2 = i.u2;
            if_b.ex_branch_taken = br; if_b.cnt_clr = clr;
        end
    endtask

    task automatic expect_at(input int dut, input sig_e s, input int dly,
                             input logic [31:0] v, input string tag);
        sb_t e;
        e.cyc = cyc + dly; e.dut = dut; e.sig = s; e.exp = v; e.tag = tag;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] obs(input int dut, input sig_e s);
        logic [31:0] r;
        r = '0;
        if (dut == 0) begin
            case (s)
                SIG_STALL:  r = 32'(if_a.stall);
                SIG_FLUSH:  r = 32'(if_a.flush_de);
                SIG_BUBBLE: r = 32'(if_a.bubble_ex);
                SIG_FS1:    r = 32'(if_a.fwd_sel_rs1);
                SIG_FS2:    r = 32'(if_a.fwd_sel_rs2);
                SIG_RETIRE: r = 32'(if_a.retire);
                SIG_CYC:    r = if_a.cycle_cnt;
                SIG_RCNT:   r = if_a.retire_cnt;
                SIG_SCNT:   r = if_a.stall_cnt;
                SIG_FCNT:   r = if_a.flush_cnt;
                default:    r = '0;
            endcase
        end else begin
            case (s)
                SIG_STALL:  r = 32'(if_b.stall);
                SIG_FLUSH:  r = 32'(if_b.flush_de);
                SIG_BUBBLE: r = 32'(if_b.bubble_ex);
                SIG_FS1:    r = 32'(if_b.fwd_sel_rs1);
                SIG_FS2:    r = 32'(if_b.fwd_sel_rs2);
                SIG_RETIRE: r = 32'(if_b.retire);
                SIG_CYC:    r = 32'(if_b.cycle_cnt);
                SIG_RCNT:   r = 32'(if_b.retire_cnt);
                SIG_SCNT:   r = 32'(if_b.stall_cnt);
                SIG_FCNT:   r = 32'(if_b.flush_cnt);
                default:    r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pop and compare every expectation due in the current cycle.
    initial forever begin
        @(negedge clk);
        sb_keep.delete();
        foreach (sb_q[i]) begin
            if (sb_q[i].cyc == cyc) check(sb_q[i].tag, obs(sb_q[i].dut, sb_q[i].sig), sb_q[i].exp);
            else sb_keep.push_back(sb_q[i]);
        end
        sb_q = sb_keep;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(0, nop(), 1'b0, 1'b0);
        drive(1, nop(), 1'b0, 1'b0);
        tick(); tick();

        // Held in reset: controls forced low even with a branch request.
        drive(0, load(5'd6), 1'b1, 1'b0);
        expect_at(0, SIG_STALL,  0, 0, "a_rst_stall");
        expect_at(0, SIG_FLUSH,  0, 0, "a_rst_flush");
        expect_at(0, SIG_BUBBLE, 0, 0, "a_rst_bubble");
        expect_at(0, SIG_RETIRE, 0, 0, "a_rst_retire");
        expect_at(0, SIG_FS1,    0, 0, "a_rst_fs1");
        expect_at(1, SIG_STALL,  0, 0, "b_rst_stall0");
        expect_at(1, SIG_RETIRE, 0, 0, "b_rst_retire0");
        tick();

        // ALU writer x5 then readers at distance 1, 2, 3.
        rst_a = 1'b1;
        drive(0, alu(5'd5, 5'd0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0);
        expect_at(0, SIG_CYC,    0, 0, "a_cyc_after_rst");
        expect_at(0, SIG_RETIRE, 2, 0, "a_retire_early");
        expect_at(0, SIG_RETIRE, 3, 1, "a_first_retire");
        tick();
        for (int d = 1; d <= 3; d++) begin
            drive(0, alu(5'd0, 5'd5, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
            expect_at(0, SIG_STALL, 0, 0, $sformatf("alu_nostall_d%0d", d));
            expect_at(0, SIG_FS1, 1, (d == 3) ? 0 : d, $sformatf("fwd_dist%0d", d));
            tick();
        end
        for (int n = 0; n < 3; n++) begin drive(0, nop(), 1'b0, 1'b0); tick(); end

        // Counter clear, then lw x6 / add x7,x6,x6.
        drive(0, nop(), 1'b0, 1'b1);
        expect_at(0, SIG_CYC,  1, 0, "a_cnt_clr_cyc");
        expect_at(0, SIG_SCNT, 1, 0, "a_cnt_clr_stall");
        tick();
        drive(0, load(5'd6), 1'b0, 1'b0);
        tick();
        drive(0, alu(5'd7, 5'd6, 5'd6, 1'b1, 1'b1), 1'b0, 1'b0);
        expect_at(0, SIG_STALL,  0, 1, "lu_stall");
        expect_at(0, SIG_BUBBLE, 0, 1, "lu_bubble");
        expect_at(0, SIG_FLUSH,  0, 0, "lu_noflush");
        tick();
        drive(0, alu(5'd7, 5'd6, 5'd6, 1'b1, 1'b1), 1'b0, 1'b0);
        expect_at(0, SIG_STALL,  0, 0, "lu_release");
        expect_at(0, SIG_BUBBLE, 0, 0, "lu_release_bubble");
        expect_at(0, SIG_FS1,    1, 2, "lu_fs1");
        expect_at(0, SIG_FS2,    1, 2, "lu_fs2");
        expect_at(0, SIG_SCNT,   1, 1, "lu_stall_cnt");
        expect_at(0, SIG_CYC,    1, 3, "a_cyc_count");
        tick();
        drive(0, nop(), 1'b0, 1'b0);
        tick();

        // Branch coinciding with load-use, then branch over a bubble.
        drive(0, load(5'd6), 1'b0, 1'b0);
        tick();
        drive(0, alu(5'd7, 5'd6, 5'd0, 1'b1, 1'b0), 1'b1, 1'b0);
        expect_at(0, SIG_FLUSH,  0, 1, "br_flush");
        expect_at(0, SIG_BUBBLE, 0, 1, "br_bubble");
        expect_at(0, SIG_STALL,  0, 0, "br_over_stall");
        expect_at(0, SIG_FCNT,   1, 1, "br_flush_cnt");
        tick();
        drive(0, alu(5'd8, 5'd6, 5'd0, 1'b1, 1'b0), 1'b1, 1'b0);
        expect_at(0, SIG_FLUSH,  0, 0, "br_bubble_noflush");
        expect_at(0, SIG_BUBBLE, 0, 0, "br_bubble_nobubble");
        expect_at(0, SIG_STALL,  0, 0, "br_after_nostall");
        expect_at(0, SIG_FS1,    1, 2, "br_after_fs1");
        expect_at(0, SIG_FCNT,   1, 1, "br_flush_cnt_hold");
        expect_at(0, SIG_SCNT,   1, 1, "br_stall_cnt_hold");
        tick();
        drive(0, nop(), 1'b0, 1'b0);
        tick();

        // Shadowed load, then x0 never forwards.
        drive(0, load(5'd6), 1'b0, 1'b0);
        tick();
        drive(0, alu(5'd6, 5'd0, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
        expect_at(0, SIG_STALL, 0, 0, "addi_x0_nostall");
        tick();
        drive(0, alu(5'd9, 5'd6, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
        expect_at(0, SIG_STALL, 0, 0, "shadow_nostall");
        expect_at(0, SIG_FS1,   1, 1, "shadow_fwd");
        tick();
        drive(0, alu(5'd0, 5'd0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0);
        tick();
        drive(0, alu(5'd10, 5'd0, 5'd0, 1'b1, 1'b1), 1'b0, 1'b0);
        expect_at(0, SIG_FS1, 1, 0, "x0_fs1");
        expect_at(0, SIG_FS2, 1, 0, "x0_fs2");
        tick();
        for (int n = 0; n < 2; n++) begin drive(0, nop(), 1'b0, 1'b0); tick(); end

        // Reset during a load-use stall with a branch request.
        drive(0, load(5'd6), 1'b0, 1'b0);
        tick();
        rst_a = 1'b0;
        drive(0, alu(5'd7, 5'd6, 5'd6, 1'b1, 1'b1), 1'b1, 1'b0);
        expect_at(0, SIG_STALL,  0, 0, "rst_abort_stall");
        expect_at(0, SIG_FLUSH,  0, 0, "rst_abort_flush");
        expect_at(0, SIG_BUBBLE, 0, 0, "rst_abort_bubble");
        tick();
        rst_a = 1'b1;
        drive(0, alu(5'd7, 5'd6, 5'd6, 1'b1, 1'b1), 1'b0, 1'b0);
        expect_at(0, SIG_STALL,  0, 0, "post_rst_stall");
        expect_at(0, SIG_BUBBLE, 0, 0, "post_rst_bubble");
        expect_at(0, SIG_RETIRE, 0, 0, "post_rst_retire");
        expect_at(0, SIG_CYC,    0, 0, "post_rst_cyc");
        expect_at(0, SIG_FS1,    1, 0, "post_rst_fwd");
        tick();
        drive(0, nop(), 1'b0, 1'b0);
        tick();

        // Instance B: two-cycle load-use stall, then counter saturation.
        rst_b = 1'b1;
        drive(1, load(5'd6), 1'b0, 1'b0);
        expect_at(1, SIG_CYC, 0, 0, "b_cyc0");
        tick();
        drive(1, alu(5'd7, 5'd6, 5'd6, 1'b1, 1'b1), 1'b0, 1'b0);
        expect_at(1, SIG_STALL, 0, 1, "b_stall1");
        tick();
        drive(1, alu(5'd7, 5'd6, 5'd6, 1'b1, 1'b1), 1'b0, 1'b0);
        expect_at(1, SIG_STALL,  0, 1, "b_stall2");
        expect_at(1, SIG_BUBBLE, 0, 1, "b_bubble2");
        tick();
        drive(1, alu(5'd7, 5'd6, 5'd6, 1'b1, 1'b1), 1'b0, 1'b0);
        expect_at(1, SIG_STALL, 0, 0, "b_release");
        expect_at(1, SIG_FS1,   1, 3, "b_fs1");
        expect_at(1, SIG_FS2,   1, 3, "b_fs2");
        expect_at(1, SIG_SCNT,  1, 2, "b_stall_cnt");
        tick();
        for (int n = 4; n <= 16; n++) begin
            drive(1, nop(), 1'b0, 1'b0);
            if (n == 14) expect_at(1, SIG_CYC, 0, 14, "b_cyc14");
            tick();
        end
        drive(1, alu(5'd9, 5'd0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0);
        tick();
        drive(1, nop(), 1'b0, 1'b0);
        tick();
        drive(1, load(5'd10), 1'b0, 1'b0);
        tick();
        drive(1, nop(), 1'b0, 1'b0);
        expect_at(1, SIG_CYC,  0, 15, "b_cyc_sat");
        expect_at(1, SIG_RCNT, 0, 2,  "b_retire_cnt");
        tick();
        rst_b = 1'b0;
        drive(1, alu(5'd11, 5'd10, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
        expect_at(1, SIG_STALL,  0, 0, "b_rst_stall");
        expect_at(1, SIG_BUBBLE, 0, 0, "b_rst_bubble");
        expect_at(1, SIG_RETIRE, 0, 0, "b_rst_retire");
        tick();
        rst_b = 1'b1;
        expect_at(1, SIG_CYC,    0, 0, "b_rst_cyc");
        expect_at(1, SIG_RCNT,   0, 0, "b_rst_rcnt");
        expect_at(1, SIG_SCNT,   0, 0, "b_rst_scnt");
        expect_at(1, SIG_RETIRE, 0, 0, "b_post_rst_retire");
        expect_at(1, SIG_STALL,  0, 0, "b_post_rst_stall");
        tick();
        drive(1, nop(), 1'b0, 1'b0);
        tick(); tick();

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
